writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Final pipeline stage, directly downstream of the memory stage. Consumes its registered
//  targets/results/flags plus data-memory read data, commits up to two register writes per
//  cycle into an internal 32x32 register file, supplies decode read ports and registered
//  forwarding info, and owns the sticky halt that stops the core.
// PARAMETERS
//  NREGS   32  register count; r0 hardwired to zero
//  XLEN    32  data width
// PORTS
//  clk          in   1     core clock, all state on posedge
//  rst_n        in   1     asynchronous active-low reset
//  halt         in   1     global stall; state frozen while 1
//  bubble_in    in   1     slot from memory stage is empty
//  halt_in      in   1     slot holds a halt instruction
//  opcode_in    in   5     opcode of slot
//  tgt_in_1     in   5     primary destination register
//  tgt_in_2     in   5     secondary destination (e.g. address update)
//  result_in_1  in   XLEN  ALU result for tgt_in_1
//  result_in_2  in   XLEN  result for tgt_in_2
//  is_load      in   1     slot is a load; tgt_in_1 takes mem_rdata
//  is_store     in   1     slot is a store; tgt_in_1 write suppressed
//  mem_rdata    in   XLEN  data-memory read data aligned with slot
//  raddr_a/b    in   5     decode read addresses
//  rdata_a/b    out  XLEN  decode read data (combinational, write-bypassed)
//  fwd_tgt_1/2  out  5     registered last-committed targets (0 = none)
//  fwd_data_1/2 out  XLEN  registered last-committed data
//  retire       out  1     registered pulse: one instruction committed last cycle
//  halt_out     out  1     sticky core halt
// BEHAVIOUR
//  - Reset (async, rst_n=0): all regs 0, fwd_tgt/data 0, retire 0, halt_out 0.
//  - Commit condition C = ~halt & ~bubble_in & ~halt_out; evaluated at posedge.
//  - Port 1 data = is_load ? mem_rdata : result_in_1; written if C & ~is_store & tgt_in_1!=0.
//  - Port 2 writes result_in_2 if C & tgt_in_2!=0.
//  - tgt_in_1==tgt_in_2!=0: port 1 wins; port 2 dropped.
//  - Writes to r0 ignored; rdata reads of r0 always 0.
//  - rdata_a/b: if address matches a write committing this cycle, return write data
//    (port-1 priority), else array contents. Zero-cycle bypass.
//  - fwd_*: latency 1; on C updated to the effective written tgt/data (tgt 0 when that
//    port did not write); on ~halt & ~C cleared to 0; held while halt.
//  - retire: 1 for exactly one cycle after a cycle with C=1 (halt instruction counts).
//  - halt_out: set on posedge when C & halt_in; remains 1 until reset. The halt
//    instruction's own writes still commit in that cycle; all later slots are discarded.
//  - halt=1 freezes everything (incl. retire held, counter held); bubble with halt_in ignored.
//  - is_load & is_store both 1: illegal; store wins (no port-1 write), assert in sim.
//  - Reset mid-operation clears regfile and sticky halt immediately, no clock needed.
// CONFIGURATION
//  WB_RETIRE_COUNT_EN defined: adds output retire_count [63:0], reset 0, +1 per cycle
//  with C=1, wraps at 2^64-1 -> 0. Undefined: port and counter absent; all else identical.
// STRUCTURE
//  - Shared package core_pkg: XLEN, NREGS, opcode localparams, reg index typedef.
//  - One sub-module: regfile_2w2r (2 write ports with port-1 priority, 2 bypassed read ports,
//    r0 zero, async clear). Stage logic (commit gating, mux, fwd, halt, counter) in top.
// TESTING
//  - load r5: C, is_load, tgt1=5, mem_rdata=32'hDEAD_BEEF -> same cycle rdata_a(5)=DEADBEEF,
//    next cycle reg[5]=DEADBEEF, fwd_tgt_1=5, retire=1.
//  - dual write tgt1=3/res=11, tgt2=4/res=22 -> r3=11, r4=22; then tgt1=tgt2=7 res 1/2 -> r7=1.
//  - bubble_in=1 with tgt1=9 res=5 -> r9 unchanged, fwd_tgt_1=0, retire=0; store tgt1=9 -> r9 unchanged.
//  - halt=1 for 3 cycles with valid slot -> no write, fwd/retire held; release -> commits once.
//  - halt_in on valid slot writing r2=8 -> r2=8, halt_out=1 next cycle; later slots ignored;
//    rst_n pulse mid-cycle -> halt_out=0, all regs 0 asynchronously.
//  - WB_RETIRE_COUNT_EN: 10 commits mixed with 4 bubbles and 2 stall cycles -> retire_count=10;
//    tgt=0 writes -> r0 reads 0.

Source files
------------

// File: rtl/core_pkg.sv
// Purpose : shared core types and constants (data width, register count, opcodes).
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: XLEN, NREGS, reg_idx_t, xword_t, opcode localparams.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int RIDX_W = $clog2(NREGS);

  typedef logic [RIDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xword_t;

  // Opcode encodings carried alongside each slot; writeback only needs the
  // decoded is_load/is_store/halt_in flags, the raw opcode is informational.
  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_ALU   = 5'h01;
  localparam logic [4:0] OP_LOAD  = 5'h02;
  localparam logic [4:0] OP_STORE = 5'h03;
  localparam logic [4:0] OP_HALT  = 5'h1f;

endpackage

// File: rtl/regfile_2w2r.sv
// Purpose : 32x32 register file, two write ports (port 1 wins on same index),
//           two read ports with same-cycle write bypass, r0 hardwired to zero.
// Latency : writes visible in the array after 1 clk, on read ports in 0 clk.
// Backpressure: none; caller gates the write enables.
// Ports   : clk, rst_n (async clear of the whole array), we_1/waddr_1/wdata_1,
//           we_2/waddr_2/wdata_2, raddr_a/rdata_a, raddr_b/rdata_b.
module regfile_2w2r
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_1,
  input  logic [RIDX_W-1:0] waddr_1,
  input  logic [XLEN-1:0]   wdata_1,
  input  logic              we_2,
  input  logic [RIDX_W-1:0] waddr_2,
  input  logic [XLEN-1:0]   wdata_2,
  input  logic [RIDX_W-1:0] raddr_a,
  output logic [XLEN-1:0]   rdata_a,
  input  logic [RIDX_W-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_b
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wen_1;
  logic            wen_2;

  // r0 is never written; port 2 yields to port 1 on a shared index.
  assign wen_1 = we_1 && (waddr_1 != '0);
  assign wen_2 = we_2 && (waddr_2 != '0) && !(wen_1 && (waddr_1 == waddr_2));

  always_comb begin
    regs_d = regs_q;
    if (wen_2) regs_d[waddr_2] = wdata_2;
    if (wen_1) regs_d[waddr_1] = wdata_1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Bypass: a write committing this cycle is returned immediately, port 1 first.
  assign rdata_a = (raddr_a == '0)                      ? '0      :
                   (wen_1 && (waddr_1 == raddr_a))      ? wdata_1 :
                   (wen_2 && (waddr_2 == raddr_a))      ? wdata_2 :
                                                          regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0)                      ? '0      :
                   (wen_1 && (waddr_1 == raddr_b))      ? wdata_1 :
                   (wen_2 && (waddr_2 == raddr_b))      ? wdata_2 :
                                                          regs_q[raddr_b];

endmodule

// File: rtl/writeback_stage.sv
// Purpose : final pipeline stage; commits up to two register writes per slot,
//           drives bypassed decode reads, registered forwarding, retire pulse
//           and the sticky core halt.
// Latency : regfile reads 0 clk (bypassed); fwd_*, retire, halt_out 1 clk.
// Backpressure: halt=1 freezes all state; no ready is returned upstream.
// Ports   : clk, rst_n, halt, slot inputs (bubble_in, halt_in, opcode_in,
//           tgt_in_1/2, result_in_1/2, is_load, is_store, mem_rdata),
//           raddr_a/b -> rdata_a/b, fwd_tgt_1/2, fwd_data_1/2, retire, halt_out.
// Config  : WB_RETIRE_COUNT_EN adds output retire_count[63:0] (commits counted).
module writeback_stage
  import core_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              bubble_in,
  input  logic              halt_in,
  input  logic [4:0]        opcode_in,
  input  logic [RIDX_W-1:0] tgt_in_1,
  input  logic [RIDX_W-1:0] tgt_in_2,
  input  logic [XLEN-1:0]   result_in_1,
  input  logic [XLEN-1:0]   result_in_2,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [RIDX_W-1:0] raddr_a,
  input  logic [RIDX_W-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_a,
  output logic [XLEN-1:0]   rdata_b,
  output logic [RIDX_W-1:0] fwd_tgt_1,
  output logic [RIDX_W-1:0] fwd_tgt_2,
  output logic [XLEN-1:0]   fwd_data_1,
  output logic [XLEN-1:0]   fwd_data_2,
  output logic              retire,
`ifdef WB_RETIRE_COUNT_EN
  output logic [63:0]       retire_count,
`endif
  output logic              halt_out
);

  logic              commit;
  logic              wr_1;
  logic              wr_2;
  logic [XLEN-1:0]   wdata_1;

  logic [RIDX_W-1:0] fwd_tgt_1_q,  fwd_tgt_1_d;
  logic [RIDX_W-1:0] fwd_tgt_2_q,  fwd_tgt_2_d;
  logic [XLEN-1:0]   fwd_data_1_q, fwd_data_1_d;
  logic [XLEN-1:0]   fwd_data_2_q, fwd_data_2_d;
  logic              retire_q,     retire_d;
  logic              halt_out_q,   halt_out_d;

  // The opcode is carried for visibility only; decoded flags drive the logic.
  logic unused_opcode;
  assign unused_opcode = ^opcode_in;

  // Once halted, every later slot is discarded until reset.
  assign commit  = ~halt & ~bubble_in & ~halt_out_q;
  assign wdata_1 = is_load ? mem_rdata : result_in_1;
  assign wr_1    = commit & ~is_store & (tgt_in_1 != '0);
  // Port 2 is dropped only when port 1 actually writes the same register.
  assign wr_2    = commit & (tgt_in_2 != '0) & ~(wr_1 & (tgt_in_1 == tgt_in_2));

  regfile_2w2r u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_1    (wr_1),
    .waddr_1 (tgt_in_1),
    .wdata_1 (wdata_1),
    .we_2    (wr_2),
    .waddr_2 (tgt_in_2),
    .wdata_2 (result_in_2),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (raddr_b),
    .rdata_b (rdata_b)
  );

  always_comb begin
    fwd_tgt_1_d  = fwd_tgt_1_q;
    fwd_tgt_2_d  = fwd_tgt_2_q;
    fwd_data_1_d = fwd_data_1_q;
    fwd_data_2_d = fwd_data_2_q;
    retire_d     = retire_q;
    halt_out_d   = halt_out_q;
    if (!halt) begin
      // Non-committing cycles clear forwarding since wr_* are low.
      fwd_tgt_1_d  = wr_1 ? tgt_in_1    : '0;
      fwd_data_1_d = wr_1 ? wdata_1     : '0;
      fwd_tgt_2_d  = wr_2 ? tgt_in_2    : '0;
      fwd_data_2_d = wr_2 ? result_in_2 : '0;
      retire_d     = commit;
      halt_out_d   = halt_out_q | (commit & halt_in);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_tgt_1_q  <= '0;
      fwd_tgt_2_q  <= '0;
      fwd_data_1_q <= '0;
      fwd_data_2_q <= '0;
      retire_q     <= 1'b0;
      halt_out_q   <= 1'b0;
    end else begin
      fwd_tgt_1_q  <= fwd_tgt_1_d;
      fwd_tgt_2_q  <= fwd_tgt_2_d;
      fwd_data_1_q <= fwd_data_1_d;
      fwd_data_2_q <= fwd_data_2_d;
      retire_q     <= retire_d;
      halt_out_q   <= halt_out_d;
    end
  end

  assign fwd_tgt_1  = fwd_tgt_1_q;
  assign fwd_tgt_2  = fwd_tgt_2_q;
  assign fwd_data_1 = fwd_data_1_q;
  assign fwd_data_2 = fwd_data_2_q;
  assign retire     = retire_q;
  assign halt_out   = halt_out_q;

`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retire_count_q, retire_count_d;

  // Wraps naturally from all-ones back to zero.
  always_comb begin
    retire_count_d = retire_count_q;
    if (commit) retire_count_d = retire_count_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_count_q <= '0;
    else        retire_count_q <= retire_count_d;
  end

  assign retire_count = retire_count_q;
`endif

  // Load and store together is illegal; store semantics apply if it happens.
  a_no_load_store: assert property (@(posedge clk) disable iff (!rst_n)
                                    !(!bubble_in && is_load && is_store));

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, bubble_in, halt_in, is_load, is_store;
  logic [4:0]  opcode_in, tgt_in_1, tgt_in_2, raddr_a, raddr_b;
  logic [31:0] result_in_1, result_in_2, mem_rdata;
  logic [31:0] rdata_a, rdata_b, fwd_data_1, fwd_data_2;
  logic [4:0]  fwd_tgt_1, fwd_tgt_2;
  logic        retire, halt_out;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retire_count;
`endif

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .bubble_in(bubble_in),
    .halt_in(halt_in), .opcode_in(opcode_in), .tgt_in_1(tgt_in_1),
    .tgt_in_2(tgt_in_2), .result_in_1(result_in_1), .result_in_2(result_in_2),
    .is_load(is_load), .is_store(is_store), .mem_rdata(mem_rdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .fwd_tgt_1(fwd_tgt_1), .fwd_tgt_2(fwd_tgt_2), .fwd_data_1(fwd_data_1),
    .fwd_data_2(fwd_data_2), .retire(retire),
`ifdef WB_RETIRE_COUNT_EN
    .retire_count(retire_count),
`endif
    .halt_out(halt_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: architectural register contents and last-cycle outcomes.
  logic [31:0] m_rf [32];
  logic [31:0] m_nx [32];
  logic [4:0]  m_ft1, m_ft2;
  logic [31:0] m_fd1, m_fd2;
  logic        m_ret, m_hout;
  logic [63:0] m_cnt;
  logic        m_c, m_w1, m_w2;
  logic [31:0] m_d1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_ft1 = '0; m_ft2 = '0; m_fd1 = '0; m_fd2 = '0;
    m_ret = 1'b0; m_hout = 1'b0; m_cnt = '0;
  endtask

  // What the register file will hold once the current slot has committed:
  // port 2 is applied first so port 1 overwrites it on a shared index.
  task automatic predict();
    m_c  = !halt && !bubble_in && !m_hout;
    m_d1 = is_load ? mem_rdata : result_in_1;
    m_w1 = m_c && !is_store && (tgt_in_1 != 0);
    m_w2 = m_c && (tgt_in_2 != 0) && !(m_w1 && tgt_in_1 == tgt_in_2);
    for (int i = 0; i < 32; i++) m_nx[i] = m_rf[i];
    if (m_w2) m_nx[tgt_in_2] = result_in_2;
    if (m_w1) m_nx[tgt_in_1] = m_d1;
  endtask

  task automatic model_clock();
    predict();
    for (int i = 0; i < 32; i++) m_rf[i] = m_nx[i];
    if (!halt) begin
      m_ft1 = m_w1 ? tgt_in_1 : 5'd0;
      m_fd1 = m_w1 ? m_d1 : 32'd0;
      m_ft2 = m_w2 ? tgt_in_2 : 5'd0;
      m_fd2 = m_w2 ? result_in_2 : 32'd0;
      m_ret = m_c;
      m_hout = m_hout || (m_c && halt_in);
      if (m_c) m_cnt = m_cnt + 64'd1;
    end
  endtask

  task automatic check_regs();
    chk("fwd_tgt_1", fwd_tgt_1, m_ft1);
    chk("fwd_tgt_2", fwd_tgt_2, m_ft2);
    chk("fwd_data_1", fwd_data_1, m_fd1);
    chk("fwd_data_2", fwd_data_2, m_fd2);
    chk("retire", retire, m_ret);
    chk("halt_out", halt_out, m_hout);
`ifdef WB_RETIRE_COUNT_EN
    chk("retire_count", retire_count, m_cnt);
`endif
  endtask

  // Called at a negedge with the slot already driven.
  task automatic cycle();
    #1;
    predict();
    chk("rdata_a", rdata_a, (raddr_a == 0) ? 32'd0 : m_nx[raddr_a]);
    chk("rdata_b", rdata_b, (raddr_b == 0) ? 32'd0 : m_nx[raddr_b]);
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_regs();
  endtask

  task automatic slot(input logic bub, input logic hin, input logic [4:0] t1,
                      input logic [4:0] t2, input logic [31:0] r1, input logic [31:0] r2,
                      input logic ld, input logic st, input logic [31:0] md);
    bubble_in = bub; halt_in = hin; tgt_in_1 = t1; tgt_in_2 = t2;
    result_in_1 = r1; result_in_2 = r2; is_load = ld; is_store = st; mem_rdata = md;
    opcode_in = hin ? 5'h1f : ld ? 5'h02 : st ? 5'h03 : 5'h01;
  endtask

  task automatic reset_pulse();
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_halt_out", halt_out, 0);
    chk("rst_async_rdata_a", rdata_a, 0);
    chk("rst_async_retire", retire, 0);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  int pat [16] = '{0, 0, 1, 0, 2, 0, 0, 1, 0, 0, 2, 1, 0, 0, 1, 0};

  initial begin
    rst_n = 1'b0; halt = 1'b0; raddr_a = '0; raddr_b = '0;
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_halt_out", halt_out, 0);
    chk("rst_retire", retire, 0);
    chk("rst_fwd_tgt_1", fwd_tgt_1, 0);
    chk("rst_fwd_data_2", fwd_data_2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i += 4) begin
      raddr_a = 5'(i); raddr_b = 5'(31 - i);
      #1;
      chk("rst_rf_a", rdata_a, 0);
      chk("rst_rf_b", rdata_b, 0);
      @(negedge clk);
    end

    // Load into r5, bypassed in the same cycle.
    slot(0, 0, 5, 0, 32'h1234, 0, 1, 0, 32'hDEAD_BEEF);
    raddr_a = 5; raddr_b = 0;
    #1 chk("load_bypass", rdata_a, 32'hDEAD_BEEF);
    cycle();
    chk("load_fwd_tgt", fwd_tgt_1, 5);
    chk("load_fwd_data", fwd_data_1, 32'hDEAD_BEEF);
    chk("load_retire", retire, 1);
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("load_reg5", rdata_a, 32'hDEAD_BEEF);
    cycle();

    // Dual write, then same-target collision.
    slot(0, 0, 3, 4, 11, 22, 0, 0, 0);
    cycle();
    slot(0, 0, 7, 7, 1, 2, 0, 0, 0);
    raddr_a = 3; raddr_b = 4;
    #1;
    chk("dual_r3", rdata_a, 11);
    chk("dual_r4", rdata_b, 22);
    cycle();
    chk("collide_fwd_tgt_2", fwd_tgt_2, 0);
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0);
    raddr_a = 7;
    #1 chk("collide_r7", rdata_a, 1);
    cycle();

    // Bubble and store do not write r9.
    slot(1, 0, 9, 0, 5, 0, 0, 0, 0);
    raddr_a = 9;
    cycle();
    chk("bubble_fwd", fwd_tgt_1, 0);
    chk("bubble_retire", retire, 0);
    slot(0, 0, 9, 0, 5, 0, 0, 1, 0);
    cycle();
    chk("store_retire", retire, 1);
    #1 chk("store_r9", rdata_a, 0);

    // Stall freezes state for three cycles, then the slot commits once.
    slot(0, 0, 10, 0, 32'h55, 0, 0, 0, 0);
    cycle();
    halt = 1'b1;
    slot(0, 0, 11, 0, 32'h66, 0, 0, 0, 0);
    raddr_a = 11;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_retire_held", retire, 1);
      chk("stall_fwd_held", fwd_tgt_1, 10);
      chk("stall_no_write", rdata_a, 0);
    end
    halt = 1'b0;
    cycle();
    chk("release_fwd", fwd_tgt_1, 11);
    slot(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("release_r11", rdata_a, 32'h66);
    cycle();
    chk("release_once", retire, 0);

    // Halt instruction commits its own write, then discards later slots.
    slot(0, 1, 2, 0, 8, 0, 0, 0, 0);
    cycle();
    chk("halt_set", halt_out, 1);
    slot(0, 0, 6, 0, 99, 0, 0, 0, 0);
    raddr_a = 2; raddr_b = 6;
    #1;
    chk("halt_r2", rdata_a, 8);
    chk("halt_r6", rdata_b, 0);
    cycle();
    chk("halted_retire", retire, 0);
    chk("halted_fwd", fwd_tgt_1, 0);
    reset_pulse();
    cycle();

    // Ten commits among four bubbles and two stalls, all aimed at r0.
    raddr_a = 0; raddr_b = 0;
    for (int i = 0; i < 16; i++) begin
      halt = (pat[i] == 2);
      slot(pat[i] == 1, 0, 0, 0, 32'hFFFF_0000 + 32'(i), 32'h77, 0, 0, 0);
      cycle();
      chk("r0_zero", rdata_a, 0);
    end
    halt = 1'b0;
`ifdef WB_RETIRE_COUNT_EN
    chk("count_ten", retire_count, 10);
`endif

    // Randomized traffic against the reference model.
    for (int k = 0; k < 600; k++) begin
      if (m_hout && $urandom_range(0, 5) == 0) begin
        reset_pulse();
      end else begin
        int lk;
        logic [4:0] t1, t2;
        lk = $urandom_range(0, 3);
        t1 = 5'($urandom_range(0, 31));
        t2 = ($urandom_range(0, 3) == 0) ? t1 : 5'($urandom_range(0, 31));
        halt = ($urandom_range(0, 9) == 0);
        slot($urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0, t1, t2,
             $urandom, $urandom, lk == 0, lk == 1, $urandom);
        raddr_a = ($urandom_range(0, 1) == 0) ? t1 : 5'($urandom_range(0, 31));
        raddr_b = ($urandom_range(0, 1) == 0) ? t2 : 5'($urandom_range(0, 31));
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
